// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - LOOK-policy floor request scheduler
// Keeps a pending floor bitmap and offers the next target floor to the car controller.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  arrive,
    input  logic                  target_ready,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [1:0]            direction,
    output logic [NUM_FLOORS-1:0] pending_mask,
    output logic                  busy,
    output logic                  req_drop
);

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_OFFER,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]      target_floor_q, target_floor_d;
    logic [1:0]              direction_q, direction_d;
    logic                    req_drop_q, req_drop_d;

    logic                    has_a, has_b;
    logic [FLOOR_W-1:0]      min_a, max_b;
    logic [FLOOR_W:0]        dist_a, dist_b;
    logic [FLOOR_W-1:0]      sel_floor;
    logic [1:0]              sel_dir;

    // Arrive clears first, then a request sets, so a same-floor request survives.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (arrive && current_floor == FLOOR_W'(i)) begin
                pending_d[i] = 1'b0;
            end
            if (req_valid && req_floor == FLOOR_W'(i)) begin
                pending_d[i] = 1'b1;
            end
        end
        req_drop_d = req_valid && ({1'b0, req_floor} >= FLOOR_LIMIT);
    end

    // Priority scans: lowest pending floor at/above the car, highest at/below it.
    always_comb begin
        has_a = 1'b0;
        min_a = '0;
        has_b = 1'b0;
        max_b = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_d[i] && FLOOR_W'(i) >= current_floor) begin
                has_a = 1'b1;
                min_a = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_d[i] && FLOOR_W'(i) <= current_floor) begin
                has_b = 1'b1;
                max_b = FLOOR_W'(i);
            end
        end
        dist_a = {1'b0, min_a} - {1'b0, current_floor};
        dist_b = {1'b0, current_floor} - {1'b0, max_b};
    end

    always_comb begin
        sel_floor = min_a;
        sel_dir   = DIR_UP;
        case (direction_q)
            DIR_UP: begin
                if (!has_a) begin
                    sel_floor = max_b;
                    sel_dir   = DIR_DOWN;
                end
            end
            DIR_DOWN: begin
                if (has_b) begin
                    sel_floor = max_b;
                    sel_dir   = DIR_DOWN;
                end
            end
            default: begin
                if (has_a && min_a == current_floor) begin
                    sel_floor = current_floor;
                    sel_dir   = DIR_IDLE;
                end else if (has_a && has_b) begin
                    if (dist_b < dist_a) begin
                        sel_floor = max_b;
                        sel_dir   = DIR_DOWN;
                    end
                end else if (!has_a) begin
                    sel_floor = max_b;
                    sel_dir   = DIR_DOWN;
                end
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        direction_d    = direction_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pending_d == '0) begin
                    state_d     = S_IDLE;
                    direction_d = DIR_IDLE;
                end else begin
                    state_d        = S_OFFER;
                    target_floor_d = sel_floor;
                    direction_d    = sel_dir;
                end
            end
            S_OFFER: begin
                if (target_ready) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (arrive) begin
                    if (pending_d != '0) begin
                        state_d = S_SELECT;
                    end else begin
                        state_d     = S_IDLE;
                        direction_d = DIR_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            target_floor_q <= '0;
            direction_q    <= DIR_IDLE;
            req_drop_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_floor_q <= target_floor_d;
            direction_q    <= direction_d;
            req_drop_q     <= req_drop_d;
        end
    end

    assign target_valid = (state_q == S_OFFER);
    assign target_floor = target_floor_q;
    assign direction    = direction_q;
    assign pending_mask = pending_q;
    assign busy         = (state_q != S_IDLE);
    assign req_drop     = req_drop_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - scoreboard bench for elevator_request_scheduler
// Directed request sequences; a monitor checks every new offer against queued expectations.
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic [FW-1:0] current_floor;
    logic          arrive;
    logic          target_ready;
    logic          target_valid;
    logic [FW-1:0] target_floor;
    logic [1:0]    direction;
    logic [NF-1:0] pending_mask;
    logic          busy;
    logic          req_drop;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .current_floor(current_floor),
        .arrive       (arrive),
        .target_ready (target_ready),
        .target_valid (target_valid),
        .target_floor (target_floor),
        .direction    (direction),
        .pending_mask (pending_mask),
        .busy         (busy),
        .req_drop     (req_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] floor;
        logic [1:0]    dir;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_exp;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          prev_valid = 1'b0;
    logic [FW-1:0] held_floor = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every fresh offer must match the oldest expectation; a held offer must not change.
    always @(negedge clk) begin
        if (!reset && target_valid) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_offer: got floor %0d with nothing expected", target_floor);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("offer_floor", 32'(target_floor), 32'(mon_exp.floor));
                    check("offer_dir", 32'(direction), 32'(mon_exp.dir));
                end
                held_floor = target_floor;
            end else begin
                check("offer_stable", 32'(target_floor), 32'(held_floor));
            end
        end
        prev_valid = target_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input int f);
        req_valid = 1'b1;
        req_floor = f[FW-1:0];
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!target_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, "_offer_timeout"}, 32'(target_valid), 32'd1);
    endtask

    task automatic serve(input int c);
        wait_valid("serve");
        target_ready = 1'b1;
        @(negedge clk);
        target_ready  = 1'b0;
        current_floor = c[FW-1:0];
        arrive        = 1'b1;
        @(negedge clk);
        arrive = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_dir"}, 32'(direction), 32'd0);
        check({name, "_pending"}, 32'(pending_mask), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_floor     = '0;
        current_floor = 4'd5;
        arrive        = 1'b0;
        target_ready  = 1'b0;
        #12;
        check("rst_valid", 32'(target_valid), 32'd0);
        check("rst_floor", 32'(target_floor), 32'd0);
        check("rst_drop", 32'(req_drop), 32'd0);
        check_idle("rst");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // c=5: nearest of {3,8} is 3 (down), then 8 (up).
        exp_q.push_back('{4'd3, 2'b10});
        exp_q.push_back('{4'd8, 2'b01});
        req(3);
        req(8);
        tick();
        check("t1_latency_valid", 32'(target_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        serve(3);
        serve(8);
        check_idle("t1_end");

        // c=2 sweeping up: 4, 9, then reverse to 1.
        current_floor = 4'd2;
        exp_q.push_back('{4'd4, 2'b01});
        exp_q.push_back('{4'd9, 2'b01});
        exp_q.push_back('{4'd1, 2'b10});
        req(4);
        req(9);
        wait_valid("t2");
        req(1);
        serve(4);
        serve(9);
        serve(1);
        check_idle("t2_end");

        // Out-of-range requests are dropped for exactly one cycle.
        req(12);
        check("t3_drop12", 32'(req_drop), 32'd1);
        check("t3_pending12", 32'(pending_mask), 32'd0);
        tick();
        check("t3_drop_clear", 32'(req_drop), 32'd0);
        check("t3_no_offer", 32'(target_valid), 32'd0);
        req(10);
        check("t3_drop10", 32'(req_drop), 32'd1);
        check("t3_pending10", 32'(pending_mask), 32'd0);
        tick();

        // Arrive and request at the same floor in WAIT: set wins, 6 is offered again.
        exp_q.push_back('{4'd6, 2'b01});
        exp_q.push_back('{4'd6, 2'b01});
        req(6);
        wait_valid("t4");
        target_ready = 1'b1;
        tick();
        target_ready  = 1'b0;
        current_floor = 4'd6;
        arrive        = 1'b1;
        req_valid     = 1'b1;
        req_floor     = 4'd6;
        tick();
        arrive    = 1'b0;
        req_valid = 1'b0;
        check("t4_pending6", 32'(pending_mask[6]), 32'd1);
        serve(6);
        check_idle("t4_end");

        // Offer of 9 held while ready stays low and a request for 4 arrives.
        current_floor = 4'd2;
        exp_q.push_back('{4'd9, 2'b01});
        exp_q.push_back('{4'd4, 2'b10});
        req(9);
        wait_valid("t5");
        req(4);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 32'(target_valid), 32'd1);
            check("t5_hold_floor", 32'(target_floor), 32'd9);
            tick();
        end
        serve(9);
        serve(4);
        check_idle("t5_end");

        // Asynchronous reset in the middle of an offer.
        current_floor = 4'd2;
        exp_q.push_back('{4'd7, 2'b01});
        req(7);
        wait_valid("t6");
        check("t6_pending_before", 32'(pending_mask), 32'h80);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(target_valid), 32'd0);
        check_idle("t6_async");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t6_post_valid", 32'(target_valid), 32'd0);
        check_idle("t6_post");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Collects floor requests into a pending bitmap and picks the next target floor for the elevator car controller with a LOOK policy: keep serving in the current direction, then reverse.
- Hands each target to the car over a valid/ready handshake, then waits for an arrival pulse before choosing the next one.
- Sits between the request inputs (buttons) and the car motion/door FSM.

Parameters:
NUM_FLOORS, 16, number of served floors; must be <= 2**FLOOR_W
FLOOR_W, 4, width of all floor-number signals

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  floor request strobe, one request per cycle
req_floor  input  FLOOR_W  requested floor, sampled when req_valid=1
current_floor  input  FLOOR_W  car position reported by car controller
arrive  input  1  one-cycle pulse: car stopped at current_floor
target_ready  input  1  car controller accepts target_floor
target_valid  output  1  target_floor is offered
target_floor  output  FLOOR_W  floor the car must travel to
direction  output  2  00 idle, 01 up, 10 down (registered LOOK direction)
pending_mask  output  NUM_FLOORS  outstanding requests, bit i = floor i
busy  output  1  1 when FSM is not IDLE
req_drop  output  1  one-cycle pulse: request ignored (req_floor >= NUM_FLOORS)

Behaviour:
- Reset (async, immediate): pending_mask=0, target_valid=0, target_floor=0, direction=00, req_drop=0, FSM=IDLE. This applies mid-handshake too: target_valid drops without waiting for a clock edge.
- Pending update at each rising edge, in this order: arrive=1 clears bit[current_floor]; then req_valid=1 with an in-range floor sets bit[req_floor].
  - If both hit the same floor in the same cycle, the set wins and the bit stays 1.
  - A request for a floor already pending causes no change.
- Out-of-range request: pending unchanged; req_drop=1 for exactly the following cycle.
- FSM states: IDLE, SELECT, OFFER, WAIT.
  - IDLE: pending_mask != 0 -> SELECT.
  - SELECT: one cycle. Computes target and direction, registers target_floor, then -> OFFER. If pending becomes 0 (cleared by arrive), -> IDLE with direction=00.
  - OFFER: target_valid=1. target_floor is held stable until target_ready=1 at a rising edge, then -> WAIT with target_valid=0. New requests never change an offered target.
  - WAIT: arrive=1 -> SELECT if the post-update pending_mask is nonzero, else -> IDLE with direction=00.
  - arrive outside WAIT only clears its pending bit; no state change.
- SELECT rules (c = current_floor, A = pending floors >= c, B = pending floors <= c):
  - direction=01: A nonempty -> target = min(A). Else B nonempty -> direction=10, target = max(B).
  - direction=10: B nonempty -> target = max(B). Else -> direction=01, target = min(A).
  - direction=00:
    - bit[c] set -> target = c, direction stays 00.
    - Otherwise, if both sides are nonempty, take the nearest floor; on equal distance prefer up.
    - If only one side is nonempty, take that side.
    - direction is set to match the chosen side.
- If arrive's current_floor differs from the issued target, the target bit stays pending and is reselected on the next SELECT.
- Latency:
  - A request sampled at edge k from IDLE gives target_valid=1 after edge k+2.
  - arrive at edge k in WAIT gives target_valid=1 after edge k+1 when requests remain.
- Arithmetic: distances are computed as unsigned FLOOR_W+1 bit differences. Min/max searches are priority scans over pending_mask; they cannot wrap.
- busy = (FSM != IDLE).

Test Plan:
- c=5, IDLE; requests 3 then 8 on consecutive cycles -> first SELECT offers 3, direction=10; after ready and arrive at 3, next offer is 8 with direction=01.
- c=2, direction=01, pending {1,4,9} -> offers in order 4, 9, 1; direction flips to 10 only when offering 1; after the last arrive, FSM=IDLE and direction=00.
- NUM_FLOORS=10, req_floor=12 -> req_drop high for 1 cycle; pending_mask stays 0; target_valid stays 0.
- In WAIT, arrive at c=6 in the same cycle as a request for floor 6 -> pending bit 6 stays 1; next offer is 6 with direction unchanged.
- OFFER of 9 with target_ready held low 5 cycles while a request for 4 arrives (c=2) -> target_floor stays 9 and target_valid stays 1 until ready; the following offer is 4.
- reset asserted during OFFER -> target_valid=0, pending_mask=0, and direction=00 immediately, with no clock edge needed; after release, FSM=IDLE.
